// File: rtl/cache_ctrl_burst.sv
// Write-back direct-mapped cache controller with multi-word line fill/writeback and saturating stats.
// Optional macro WRITE_ALLOCATE_EN: clean write misses fill the line and complete as a cache write.
module cache_ctrl_burst #(
  parameter int WORDS      = 4,
  parameter int READ_WAIT  = 4,
  parameter int WRITE_WAIT = 6,
  parameter int STAT_W     = 16
) (
  input  logic                                          Clk,
  input  logic                                          ResetN,
  input  logic                                          DStrobe,
  input  logic                                          DRW,
  output logic                                          DReady,
  input  logic                                          Match,
  input  logic                                          Valid,
  input  logic                                          Dirty,
  output logic                                          Write,
  output logic                                          DirtyValue,
  output logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0]  WordSel,
  output logic                                          MStrobe,
  output logic                                          MRW,
  output logic                                          MAddrSelect,
  output logic                                          MDataSelect,
  output logic                                          DDataSelect,
  output logic                                          MDataOE,
  output logic                                          DDataOE,
  output logic [STAT_W-1:0]                             StatReadHit,
  output logic [STAT_W-1:0]                             StatReadMiss,
  output logic [STAT_W-1:0]                             StatWriteHit,
  output logic [STAT_W-1:0]                             StatWriteMiss,
  output logic [STAT_W-1:0]                             StatWriteBack
);

  localparam int WW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
  localparam logic [CW-1:0] RD_LOAD   = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] WR_LOAD   = CW'(WRITE_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LOOKUP    = 4'd1,
    WB_REQ    = 4'd2,
    WB_WAIT   = 4'd3,
    FILL_REQ  = 4'd4,
    FILL_WAIT = 4'd5,
    FILL_DATA = 4'd6,
    RD_DONE   = 4'd7,
    WR_HIT    = 4'd8,
    WM_REQ    = 4'd9,
    WM_WAIT   = 4'd10,
    WR_DONE   = 4'd11
  } state_t;

  state_t          state_r, state_s;
  logic [WW-1:0]   word_r, word_s;
  logic [CW-1:0]   wait_r, wait_s;
  logic            drw_r, drw_s;
  logic            inc_rh_s, inc_rm_s, inc_wh_s, inc_wm_s, inc_wb_s;
  logic [STAT_W-1:0] stat_rh_r, stat_rm_r, stat_wh_r, stat_wm_r, stat_wb_r;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + STAT_W'(1);
    end
  endfunction

  // Next-state, counter updates and state-decoded outputs.
  always_comb begin
    state_s     = state_r;
    word_s      = word_r;
    wait_s      = wait_r;
    drw_s       = drw_r;
    inc_rh_s    = 1'b0;
    inc_rm_s    = 1'b0;
    inc_wh_s    = 1'b0;
    inc_wm_s    = 1'b0;
    inc_wb_s    = 1'b0;
    DReady      = 1'b0;
    Write       = 1'b0;
    DirtyValue  = 1'b0;
    WordSel     = '0;
    MStrobe     = 1'b0;
    MRW         = 1'b0;
    MAddrSelect = 1'b0;
    MDataSelect = 1'b0;
    DDataSelect = 1'b0;
    MDataOE     = 1'b0;
    DDataOE     = 1'b0;
    case (state_r)
      IDLE: begin
        if (DStrobe) begin
          state_s = LOOKUP;
          drw_s   = DRW;
        end else begin
          state_s = IDLE;
        end
      end
      LOOKUP: begin
        DDataOE = drw_r;
        if (Match && Valid) begin
          if (drw_r) begin
            DReady   = 1'b1;
            inc_rh_s = 1'b1;
            state_s  = IDLE;
          end else begin
            inc_wh_s = 1'b1;
            state_s  = WR_HIT;
          end
        end else begin
          inc_rm_s = drw_r;
          inc_wm_s = ~drw_r;
          word_s   = '0;
          if (Valid && Dirty) begin
            inc_wb_s = 1'b1;
            state_s  = WB_REQ;
          end else if (drw_r) begin
            state_s = FILL_REQ;
          end else begin
`ifdef WRITE_ALLOCATE_EN
            state_s = FILL_REQ;
`else
            state_s = WM_REQ;
`endif
          end
        end
      end
      WB_REQ, WB_WAIT: begin
        MAddrSelect = 1'b1;
        MDataSelect = 1'b1;
        MDataOE     = 1'b1;
        WordSel     = word_r;
        if (state_r == WB_REQ) begin
          MStrobe = 1'b1;
          wait_s  = WR_LOAD;
        end else begin
          wait_s = wait_r - CW'(1);
        end
        // A zero load value (single-cycle write) advances straight from the request.
        if ((state_r == WB_REQ && WR_LOAD == '0) ||
            (state_r == WB_WAIT && wait_r == CW'(1))) begin
          if (word_r == LAST_WORD) begin
            word_s  = '0;
            state_s = FILL_REQ;
          end else begin
            word_s  = word_r + WW'(1);
            state_s = WB_REQ;
          end
        end else begin
          state_s = WB_WAIT;
        end
      end
      FILL_REQ: begin
        MStrobe = 1'b1;
        MRW     = 1'b1;
        WordSel = word_r;
        wait_s  = RD_LOAD;
        if (RD_LOAD == '0) begin
          state_s = FILL_DATA;
        end else begin
          state_s = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        MRW     = 1'b1;
        WordSel = word_r;
        wait_s  = wait_r - CW'(1);
        if (wait_r == CW'(1)) begin
          state_s = FILL_DATA;
        end else begin
          state_s = FILL_WAIT;
        end
      end
      FILL_DATA: begin
        Write       = 1'b1;
        DDataSelect = 1'b1;
        MRW         = 1'b1;
        WordSel     = word_r;
        if (word_r == LAST_WORD) begin
          word_s  = '0;
          state_s = drw_r ? RD_DONE : WR_HIT;
        end else begin
          word_s  = word_r + WW'(1);
          state_s = FILL_REQ;
        end
      end
      RD_DONE: begin
        DReady  = 1'b1;
        DDataOE = 1'b1;
        state_s = IDLE;
      end
      WR_HIT: begin
        Write      = 1'b1;
        DirtyValue = 1'b1;
        DReady     = 1'b1;
        state_s    = IDLE;
      end
      WM_REQ: begin
        MStrobe = 1'b1;
        MDataOE = 1'b1;
        wait_s  = WR_LOAD;
        if (WR_LOAD == '0) begin
          state_s = WR_DONE;
        end else begin
          state_s = WM_WAIT;
        end
      end
      WM_WAIT: begin
        MDataOE = 1'b1;
        wait_s  = wait_r - CW'(1);
        if (wait_r == CW'(1)) begin
          state_s = WR_DONE;
        end else begin
          state_s = WM_WAIT;
        end
      end
      WR_DONE: begin
        DReady  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        word_s  = '0;
        wait_s  = '0;
      end
    endcase
  end

  // FSM state, word/wait counters and latched CPU direction.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r <= IDLE;
      word_r  <= '0;
      wait_r  <= '0;
      drw_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      word_r  <= word_s;
      wait_r  <= wait_s;
      drw_r   <= drw_s;
    end
  end

  // Saturating event counters.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      stat_rh_r <= '0;
      stat_rm_r <= '0;
      stat_wh_r <= '0;
      stat_wm_r <= '0;
      stat_wb_r <= '0;
    end else begin
      stat_rh_r <= inc_rh_s ? sat_inc(stat_rh_r) : stat_rh_r;
      stat_rm_r <= inc_rm_s ? sat_inc(stat_rm_r) : stat_rm_r;
      stat_wh_r <= inc_wh_s ? sat_inc(stat_wh_r) : stat_wh_r;
      stat_wm_r <= inc_wm_s ? sat_inc(stat_wm_r) : stat_wm_r;
      stat_wb_r <= inc_wb_s ? sat_inc(stat_wb_r) : stat_wb_r;
    end
  end

  assign StatReadHit   = stat_rh_r;
  assign StatReadMiss  = stat_rm_r;
  assign StatWriteHit  = stat_wh_r;
  assign StatWriteMiss = stat_wm_r;
  assign StatWriteBack = stat_wb_r;

endmodule

// File: tb/tb_cache_ctrl_burst.sv
// Bench for cache_ctrl_burst: directed table, randomized transactions against a latency/event model,
// mid-transaction reset, and a small-parameter instance for saturation and zero-wait corners.
module tb_cache_ctrl_burst;

  localparam int NW = 4;
  localparam int RW = 4;
  localparam int WWT = 6;
`ifdef WRITE_ALLOCATE_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif

  logic Clk = 1'b0;
  logic ResetN = 1'b0;
  logic DStrobe = 1'b0, DRW = 1'b0, Match = 1'b0, Valid = 1'b0, Dirty = 1'b0;
  logic DReady, Write, DirtyValue, MStrobe, MRW, MAddrSelect, MDataSelect, DDataSelect, MDataOE, DDataOE;
  logic [1:0] WordSel;
  logic [15:0] StatReadHit, StatReadMiss, StatWriteHit, StatWriteMiss, StatWriteBack;

  logic s_DStrobe = 1'b0, s_DRW = 1'b0, s_Match = 1'b0, s_Valid = 1'b0, s_Dirty = 1'b0;
  logic s_DReady, s_Write, s_DirtyValue, s_MStrobe, s_MRW, s_MAddrSelect, s_MDataSelect;
  logic s_DDataSelect, s_MDataOE, s_DDataOE;
  logic [0:0] s_WordSel;
  logic [1:0] s_StatReadHit, s_StatReadMiss, s_StatWriteHit, s_StatWriteMiss, s_StatWriteBack;

  int total = 0;
  int bad = 0;
  int e_rh = 0, e_rm = 0, e_wh = 0, e_wm = 0, e_wb = 0;

  always #5 Clk = ~Clk;

  cache_ctrl_burst #(.WORDS(NW), .READ_WAIT(RW), .WRITE_WAIT(WWT), .STAT_W(16)) dut (
    .Clk(Clk), .ResetN(ResetN), .DStrobe(DStrobe), .DRW(DRW), .DReady(DReady),
    .Match(Match), .Valid(Valid), .Dirty(Dirty), .Write(Write), .DirtyValue(DirtyValue),
    .WordSel(WordSel), .MStrobe(MStrobe), .MRW(MRW), .MAddrSelect(MAddrSelect),
    .MDataSelect(MDataSelect), .DDataSelect(DDataSelect), .MDataOE(MDataOE), .DDataOE(DDataOE),
    .StatReadHit(StatReadHit), .StatReadMiss(StatReadMiss), .StatWriteHit(StatWriteHit),
    .StatWriteMiss(StatWriteMiss), .StatWriteBack(StatWriteBack)
  );

  cache_ctrl_burst #(.WORDS(1), .READ_WAIT(1), .WRITE_WAIT(1), .STAT_W(2)) u_small (
    .Clk(Clk), .ResetN(ResetN), .DStrobe(s_DStrobe), .DRW(s_DRW), .DReady(s_DReady),
    .Match(s_Match), .Valid(s_Valid), .Dirty(s_Dirty), .Write(s_Write), .DirtyValue(s_DirtyValue),
    .WordSel(s_WordSel), .MStrobe(s_MStrobe), .MRW(s_MRW), .MAddrSelect(s_MAddrSelect),
    .MDataSelect(s_MDataSelect), .DDataSelect(s_DDataSelect), .MDataOE(s_MDataOE), .DDataOE(s_DDataOE),
    .StatReadHit(s_StatReadHit), .StatReadMiss(s_StatReadMiss), .StatWriteHit(s_StatWriteHit),
    .StatWriteMiss(s_StatWriteMiss), .StatWriteBack(s_StatWriteBack)
  );

  typedef struct {
    bit drw, m, v, d;
    int lat, nrd, nwb, nwm, nwr;
    string nm;
  } vec_t;

  typedef struct {
    int lat, nrd, nwb, nwm, nwr;
    int rh, rm, wh, wm, wb;
  } exp_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input bit drw, m, v, d, input int lat, nrd, nwb, nwm, nwr, input string nm);
    vec_t r;
    r.drw = drw; r.m = m; r.v = v; r.d = d;
    r.lat = lat; r.nrd = nrd; r.nwb = nwb; r.nwm = nwm; r.nwr = nwr; r.nm = nm;
    return r;
  endfunction

  // Transaction-level model: latency and event counts from the hit/miss/dirty rules.
  function automatic exp_t model(input bit drw, m, v, d, input int words, rw, ww);
    exp_t e;
    bit hit, dmiss, fill;
    e = '{default: 0};
    hit = m & v;
    dmiss = !hit && v && d;
    if (hit) begin
      e.lat = drw ? 0 : 1;
      e.nwr = drw ? 0 : 1;
      e.rh = drw ? 1 : 0;
      e.wh = drw ? 0 : 1;
    end else begin
      fill = drw || dmiss || ALLOC;
      e.nwb = dmiss ? words : 0;
      e.nrd = fill ? words : 0;
      e.nwm = fill ? 0 : 1;
      e.lat = e.nwb * ww + (fill ? words * (rw + 1) + 1 : ww + 1);
      e.nwr = fill ? words + (drw ? 0 : 1) : 0;
      e.rm = drw ? 1 : 0;
      e.wm = drw ? 0 : 1;
      e.wb = dmiss ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk_stats(input string nm);
    chk({nm, "_rh"}, StatReadHit, e_rh);
    chk({nm, "_rm"}, StatReadMiss, e_rm);
    chk({nm, "_wh"}, StatWriteHit, e_wh);
    chk({nm, "_wm"}, StatWriteMiss, e_wm);
    chk({nm, "_wb"}, StatWriteBack, e_wb);
  endtask

  function automatic int idle_outs();
    return int'({DReady, Write, DirtyValue, WordSel, MStrobe, MRW, MAddrSelect,
                 MDataSelect, DDataSelect, MDataOE, DDataOE});
  endfunction

  // One CPU request on the main instance, observed cycle by cycle from the LOOKUP cycle.
  task automatic run_txn(input bit drw, m, v, d, input bit noise, input string nm, input exp_t x);
    exp_t st;
    int lat = -1, nrd = 0, nwb = 0, nwm = 0, nwr = 0, ndv = 0, seq_err = 0, oe = -1;
    int pk = 0, pc = 0, kind;
    DRW = drw; Match = m; Valid = v; Dirty = d; DStrobe = 1'b1;
    @(posedge Clk);
    #1 DStrobe = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge Clk);
      if (MStrobe) begin
        if (MRW && !MAddrSelect) begin
          kind = 2; if (int'(WordSel) != nrd) seq_err++; nrd++;
        end else if (!MRW && MAddrSelect && MDataSelect && MDataOE) begin
          kind = 1; if (int'(WordSel) != nwb) seq_err++; nwb++;
        end else if (!MRW && !MAddrSelect && !MDataSelect && MDataOE) begin
          kind = 3; if (WordSel != 2'd0) seq_err++; nwm++;
        end else begin
          kind = 0; seq_err++;
        end
        if (pk == 1 && c - pc != WWT) seq_err++;
        if (pk == 2 && c - pc != RW + 1) seq_err++;
        pk = kind; pc = c;
      end
      if (Write) begin
        nwr++;
        if (DirtyValue && !DDataSelect) ndv++;
        else if (!(DDataSelect && !DirtyValue)) seq_err++;
      end
      if (DReady) begin
        lat = c; oe = int'(DDataOE);
        break;
      end
      if (noise) begin
        DStrobe = 1'($urandom_range(0, 1));
        DRW = 1'($urandom_range(0, 1));
      end
    end
    DStrobe = 1'b0;
    @(negedge Clk);
    st = model(drw, m, v, d, NW, RW, WWT);
    e_rh += st.rh; e_rm += st.rm; e_wh += st.wh; e_wm += st.wm; e_wb += st.wb;
    chk({nm, "_latency"}, lat, x.lat);
    chk({nm, "_fill_strobes"}, nrd, x.nrd);
    chk({nm, "_wb_strobes"}, nwb, x.nwb);
    chk({nm, "_wm_strobes"}, nwm, x.nwm);
    chk({nm, "_writes"}, nwr, x.nwr);
    chk({nm, "_dirty_writes"}, ndv, (!drw && x.nwr > 0) ? 1 : 0);
    chk({nm, "_seq_errors"}, seq_err, 0);
    chk({nm, "_ddataoe_at_ready"}, oe, drw ? 1 : 0);
    chk({nm, "_idle_outputs"}, idle_outs(), 0);
    chk_stats(nm);
  endtask

  // Request on the small instance; returns DReady latency from LOOKUP (-1 on timeout).
  task automatic small_txn(input bit drw, m, v, d, output int lat);
    lat = -1;
    s_DRW = drw; s_Match = m; s_Valid = v; s_Dirty = d; s_DStrobe = 1'b1;
    @(posedge Clk);
    #1 s_DStrobe = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge Clk);
      if (s_DReady) begin
        lat = c;
        break;
      end
    end
    @(negedge Clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    vec_t tv;
    int lat;
    bit r_drw, r_m, r_v, r_d;

    vecs.push_back(mkv(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0, "rd_hit"));
    vecs.push_back(mkv(1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, "rd_hit_dirty"));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b0, 1'b0, 21, 4, 0, 0, 4, "rd_miss_invalid"));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b1, 1'b0, 21, 4, 0, 0, 4, "rd_miss_clean"));
    vecs.push_back(mkv(1'b1, 1'b0, 1'b1, 1'b1, 45, 4, 4, 0, 4, "rd_miss_dirty"));
    vecs.push_back(mkv(1'b1, 1'b1, 1'b0, 1'b1, 21, 4, 0, 0, 4, "rd_match_invalid"));
    vecs.push_back(mkv(1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 1, "wr_hit"));
`ifdef WRITE_ALLOCATE_EN
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 21, 4, 0, 0, 5, "wr_miss_clean"));
`else
    vecs.push_back(mkv(1'b0, 1'b0, 1'b0, 1'b0, 7, 0, 0, 1, 0, "wr_miss_clean"));
`endif
    vecs.push_back(mkv(1'b0, 1'b0, 1'b1, 1'b1, 45, 4, 4, 0, 5, "wr_miss_dirty"));

    // Power-on reset
    repeat (2) @(negedge Clk);
    chk("reset_outputs", idle_outs(), 0);
    chk_stats("reset");
    ResetN = 1'b1;
    @(negedge Clk);

    foreach (vecs[i]) begin
      tv = vecs[i];
      x = '{default: 0};
      x.lat = tv.lat; x.nrd = tv.nrd; x.nwb = tv.nwb; x.nwm = tv.nwm; x.nwr = tv.nwr;
      run_txn(tv.drw, tv.m, tv.v, tv.d, 1'b0, tv.nm, x);
    end

    for (int i = 0; i < 40; i++) begin
      r_drw = 1'($urandom_range(0, 1));
      r_m = 1'($urandom_range(0, 1));
      r_v = 1'($urandom_range(0, 1));
      r_d = 1'($urandom_range(0, 1));
      x = model(r_drw, r_m, r_v, r_d, NW, RW, WWT);
      run_txn(r_drw, r_m, r_v, r_d, 1'b1, $sformatf("rand%0d", i), x);
    end

    // Reset in the middle of a dirty read miss
    DRW = 1'b1; Match = 1'b0; Valid = 1'b1; Dirty = 1'b1; DStrobe = 1'b1;
    @(posedge Clk);
    #1 DStrobe = 1'b0;
    repeat (10) @(negedge Clk);
    chk("midreset_busy_before", MDataOE, 1);
    #2 ResetN = 1'b0;
    #1;
    chk("midreset_outputs", idle_outs(), 0);
    e_rh = 0; e_rm = 0; e_wh = 0; e_wm = 0; e_wb = 0;
    chk_stats("midreset");
    lat = 0;
    repeat (3) begin
      @(negedge Clk);
      if (DReady) lat++;
    end
    ResetN = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      if (DReady) lat++;
    end
    chk("midreset_no_dready", lat, 0);
    x = model(1'b1, 1'b1, 1'b1, 1'b0, NW, RW, WWT);
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "after_reset_hit", x);

    // Small instance: 2-bit counters, one word per line, single-cycle memory
    for (int i = 0; i < 5; i++) begin
      small_txn(1'b1, 1'b1, 1'b1, 1'b0, lat);
      chk($sformatf("small_hit%0d_latency", i), lat, 0);
      chk($sformatf("small_hit%0d_stat", i), s_StatReadHit, (i + 1 > 3) ? 3 : i + 1);
    end
    small_txn(1'b1, 1'b0, 1'b1, 1'b1, lat);
    chk("small_dirty_rd_latency", lat, 4);
    chk("small_dirty_rd_wb_stat", s_StatWriteBack, 1);
    chk("small_dirty_rd_miss_stat", s_StatReadMiss, 1);
    chk("small_hit_stat_held", s_StatReadHit, 3);
    small_txn(1'b0, 1'b0, 1'b0, 1'b0, lat);
    chk("small_clean_wr_latency", lat, ALLOC ? 3 : 2);
    chk("small_clean_wr_stat", s_StatWriteMiss, 1);
    small_txn(1'b0, 1'b1, 1'b1, 1'b0, lat);
    chk("small_wr_hit_latency", lat, 1);
    chk("small_wr_hit_stat", s_StatWriteHit, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
